// File: rtl/idex_hazard_reg_pkg.sv
// Shared definitions for the ID/EX register: control-word bit layout and status FSM codes.
package idex_hazard_reg_pkg;

  // Control word is {regwrite,memread,memwrite,memtoreg,alusrc,regdst,branch,aluop}.
  // aluop occupies the low ALUOP_W bits; flag offsets are relative to bit ALUOP_W.
  localparam int CTRL_ALUOP        = 0;
  localparam int CTRL_BRANCH_OFS   = 0;
  localparam int CTRL_REGDST_OFS   = 1;
  localparam int CTRL_ALUSRC_OFS   = 2;
  localparam int CTRL_MEMTOREG_OFS = 3;
  localparam int CTRL_MEMWRITE_OFS = 4;
  localparam int CTRL_MEMREAD_OFS  = 5;
  localparam int CTRL_REGWRITE_OFS = 6;
  localparam int CTRL_FLAGS        = 7;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HOLD   = 2'd2
  } idex_state_e;

endpackage

// File: rtl/idex_hazard_reg_hazard_detect.sv
// Combinational load-use detection and pipeline-freeze decision for the ID/EX boundary.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              idex_valid_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              ex_busy_i,
  input  logic              ex_flush_i,
  output logic              lu_o,
  output logic              stall_o
);

  // A load targeting $0 never produces a value worth waiting for.
  assign lu_o = idex_valid_i & idex_memread_i & (idex_rt_i != '0) & id_valid_i &
                ((idex_rt_i == id_rs_i) | (id_uses_rt_i & (idex_rt_i == id_rt_i)));

  assign stall_o = ~ex_flush_i & (ex_busy_i | lu_o);

endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, busy hold, branch flush and stall counter.
module idex_hazard_reg
  import idex_hazard_reg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16,
  localparam int CTRL_W = CTRL_FLAGS + ALUOP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              ex_busy,
  input  logic              ex_flush,
  output logic              idex_valid,
  output logic [REG_AW-1:0] idex_rs,
  output logic [REG_AW-1:0] idex_rt,
  output logic [REG_AW-1:0] idex_rd,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic [DATA_W-1:0] idex_pc,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output idex_state_e       idex_state
);

  localparam int BUS_W = 1 + 3 * REG_AW + CTRL_W + 4 * DATA_W;

  // The whole ID/EX slot is one packed word so bubble and hold act on every field uniformly.
  logic [BUS_W-1:0] bus_q, bus_d, id_bus;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  idex_state_e      state_q, state_d;
  logic             lu, stall;

  assign id_bus = {id_valid, id_rs, id_rt, id_rd,
                   (id_valid ? id_ctrl : {CTRL_W{1'b0}}),
                   id_rs_data, id_rt_data, id_imm, id_pc};

  assign {idex_valid, idex_rs, idex_rt, idex_rd, idex_ctrl,
          idex_rs_data, idex_rt_data, idex_imm, idex_pc} = bus_q;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .idex_valid_i  (idex_valid),
    .idex_memread_i(idex_ctrl[ALUOP_W + CTRL_MEMREAD_OFS]),
    .idex_rt_i     (idex_rt),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .ex_busy_i     (ex_busy),
    .ex_flush_i    (ex_flush),
    .lu_o          (lu),
    .stall_o       (stall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      bus_q   <= bus_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Flush outranks busy, which outranks a load-use bubble.
  always_comb begin
    state_d = state_q;
    if (ex_flush)     state_d = ST_RUN;
    else if (ex_busy) state_d = ST_HOLD;
    else if (lu)      state_d = ST_BUBBLE;
    else              state_d = ST_RUN;
  end

  always_comb begin
    bus_d = bus_q;
    if (ex_flush)     bus_d = '0;
    else if (ex_busy) bus_d = bus_q;
    else if (lu)      bus_d = '0;
    else              bus_d = id_bus;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    pc_write   = ~stall;
    ifid_write = ~stall;
    stall_cnt  = cnt_q;
    idex_state = state_q;
  end

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Self-checking bench for idex_hazard_reg: reference model feeds an expected queue per clock step.
module tb_idex_hazard_reg;
  import idex_hazard_reg_pkg::*;

  localparam int CNT_W = 8;
  localparam logic [10:0] C_LW   = 11'b11011000000;
  localparam logic [10:0] C_ADD  = 11'b10000100010;
  localparam logic [10:0] C_SW   = 11'b00101000000;
  localparam logic [10:0] C_ADDI = 11'b10001000000;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [10:0] ctrl;
    logic [31:0] rs_data, rt_data, imm, pc;
  } idex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0, id_uses_rt = 1'b0, ex_busy = 1'b0, ex_flush = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [10:0] id_ctrl = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, id_pc = '0;
  logic idex_valid, pc_write, ifid_write;
  logic [4:0] idex_rs, idex_rt, idex_rd;
  logic [10:0] idex_ctrl;
  logic [31:0] idex_rs_data, idex_rt_data, idex_imm, idex_pc;
  logic [CNT_W-1:0] stall_cnt;
  idex_state_e idex_state;

  idex_t act;
  idex_t m;
  logic [CNT_W-1:0] m_cnt;
  logic [1:0] m_st;
  logic [$bits(idex_t)-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  assign act = {idex_valid, idex_rs, idex_rt, idex_rd, idex_ctrl,
                idex_rs_data, idex_rt_data, idex_imm, idex_pc};

  idex_hazard_reg #(.DATA_W(32), .REG_AW(5), .ALUOP_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc(id_pc), .ex_busy(ex_busy), .ex_flush(ex_flush),
    .idex_valid(idex_valid), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_ctrl(idex_ctrl), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
    .idex_imm(idex_imm), .idex_pc(idex_pc), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_cnt(stall_cnt), .idex_state(idex_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m = '0;
    m_cnt = '0;
    m_st = ST_RUN;
  endtask

  // One pipeline cycle: drive ID, check freeze outputs, predict and verify the post-edge slot.
  task automatic step(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic uses, input logic [10:0] ctrl,
                      input logic busy, input logic flush);
    idex_t in_f, nxt, got_exp;
    logic lu, stall;
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = uses; id_ctrl = ctrl;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; id_pc = $urandom;
    ex_busy = busy; ex_flush = flush;
    #1;
    lu = m.valid && m.ctrl[9] && (m.rt != 5'd0) && v &&
         ((m.rt == rs) || (uses && (m.rt == rt)));
    stall = !flush && (busy || lu);
    check({tag, "_pc_write"}, pc_write, !stall);
    check({tag, "_ifid_write"}, ifid_write, !stall);
    in_f = {v, rs, rt, rd, (v ? ctrl : 11'd0), id_rs_data, id_rt_data, id_imm, id_pc};
    if (flush)      begin nxt = '0;   m_st = ST_RUN;    end
    else if (busy)  begin nxt = m;    m_st = ST_HOLD;   end
    else if (lu)    begin nxt = '0;   m_st = ST_BUBBLE; end
    else            begin nxt = in_f; m_st = ST_RUN;    end
    if (stall && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      got_exp = exp_q.pop_front();
      check({tag, "_idex"}, act, got_exp);
    end
    check({tag, "_stall_cnt"}, stall_cnt, m_cnt);
    check({tag, "_state"}, idex_state, m_st);
    m = nxt;
  endtask

  task automatic nop();
    step("nop", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 11'd0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_idex", act, '0);
    check("reset_cnt", stall_cnt, 0);
    check("reset_state", idex_state, ST_RUN);
    check("reset_pc_write", pc_write, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // lw $t0 then dependent add: one bubble, then add enters EX
    step("lw1", 1, 5'd29, 5'd8, 5'd0, 0, C_LW, 0, 0);
    step("add_stall", 1, 5'd8, 5'd9, 5'd10, 1, C_ADD, 0, 0);
    check("add_stall_ctrl_zero", idex_ctrl, 0);
    check("add_stall_cnt_one", stall_cnt, 1);
    step("add_enter", 1, 5'd8, 5'd9, 5'd10, 1, C_ADD, 0, 0);
    check("add_enter_rs", idex_rs, 8);

    // store reading rt stalls; addi ignoring rt does not
    nop();
    step("lw2", 1, 5'd29, 5'd8, 5'd0, 0, C_LW, 0, 0);
    step("sw_stall", 1, 5'd9, 5'd8, 5'd0, 1, C_SW, 0, 0);
    step("sw_enter", 1, 5'd9, 5'd8, 5'd0, 1, C_SW, 0, 0);
    step("lw3", 1, 5'd29, 5'd8, 5'd0, 0, C_LW, 0, 0);
    step("addi_nostall", 1, 5'd9, 5'd8, 5'd0, 0, C_ADDI, 0, 0);

    // load to $0 never stalls
    step("lw_zero", 1, 5'd29, 5'd0, 5'd0, 0, C_LW, 0, 0);
    step("add_r0", 1, 5'd0, 5'd0, 5'd11, 1, C_ADD, 0, 0);
    check("add_r0_cnt", stall_cnt, 2);

    // busy hold for 3 cycles, then flush overriding busy
    step("busy_load", 1, 5'd3, 5'd4, 5'd5, 1, C_ADD, 0, 0);
    for (int i = 0; i < 3; i++) step("busy_hold", 1, 5'd6, 5'd7, 5'd1, 1, C_ADD, 1, 0);
    check("busy_cnt", stall_cnt, 5);
    check("busy_rs_held", idex_rs, 3);
    step("flush_busy", 1, 5'd6, 5'd7, 5'd1, 1, C_ADD, 1, 1);
    check("flush_valid", idex_valid, 0);

    // randomised mix of hazards, holds and flushes
    for (int i = 0; i < 80; i++) begin
      logic [10:0] c;
      case ($urandom_range(0, 3))
        0: c = C_LW;
        1: c = C_ADD;
        2: c = C_SW;
        default: c = C_ADDI;
      endcase
      step("rand", 1'($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), c,
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
    end

    // counter saturation
    for (int i = 0; i < (1 << CNT_W) + 2; i++) step("sat", 0, 5'd0, 5'd0, 5'd0, 0, 11'd0, 1, 0);
    check("sat_value", stall_cnt, {CNT_W{1'b1}});
    step("sat_lw", 1, 5'd29, 5'd8, 5'd0, 0, C_LW, 0, 0);
    step("sat_lu", 1, 5'd8, 5'd1, 5'd2, 1, C_ADD, 0, 0);
    check("sat_after_lu", stall_cnt, {CNT_W{1'b1}});

    // async reset while in BUBBLE
    nop();
    step("rst_lw", 1, 5'd29, 5'd8, 5'd0, 0, C_LW, 0, 0);
    step("rst_bubble", 1, 5'd8, 5'd2, 5'd3, 1, C_ADD, 0, 0);
    check("rst_pre_state", idex_state, ST_BUBBLE);
    id_valid = 0; id_ctrl = '0;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_idex", act, '0);
    check("rst_mid_pc_write", pc_write, 1);
    check("rst_mid_ifid_write", ifid_write, 1);
    check("rst_mid_state", idex_state, ST_RUN);
    check("rst_mid_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 1, 5'd1, 5'd2, 5'd3, 1, C_ADD, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
